clock_top: RTL and testbench

Settable time-of-day clock: counts hours, minutes and seconds from a clock-derived one-second tick. A set mode freezes time and lets push buttons move a field cursor and edit the selected field. A mode button toggles the hour output between 24-hour and 12-hour format. It is the top of the clock subsystem and drives the display/readout logic with binary hr/min/sec values.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/clock_btn_edge.sv | 23 ++
 rtl/clock_top.sv | 116 +++++++++++
 tb/tb_clock_top.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, field limits and wrap/format helpers for the time-of-day clock.
package clock_pkg;

  typedef enum logic [1:0] {
    CUR_SEC = 2'd0,
    CUR_MIN = 2'd1,
    CUR_HR  = 2'd2
  } cursor_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

  // 0 maps to 12, afternoon hours fold down by 12.
  function automatic logic [4:0] to_12h(input logic [4:0] h24);
    if (h24 == 5'd0)       return 5'd12;
    else if (h24 > 5'd12)  return h24 - 5'd12;
    else                   return h24;
  endfunction

endpackage

// File: rtl/clock_btn_edge.sv
// Rising-edge detector for one level button; emits a single-cycle event per press.
module clock_btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_evt
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = i_btn;
  end

  always_ff @(posedge clk) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

  assign o_evt = rstn & i_btn & ~prev_q;

endmodule

// File: rtl/clock_top.sv
// Settable hh:mm:ss clock with run/set modes, field cursor editing and 12h/24h display.
module clock_top
  import clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 100
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_mode,
  input  logic       i_set,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  logic up_evt, down_evt, left_evt, right_evt, mode_evt;

  clock_btn_edge u_up    (.clk(i_clk), .rstn(i_rstn), .i_btn(i_up),    .o_evt(up_evt));
  clock_btn_edge u_down  (.clk(i_clk), .rstn(i_rstn), .i_btn(i_down),  .o_evt(down_evt));
  clock_btn_edge u_left  (.clk(i_clk), .rstn(i_rstn), .i_btn(i_left),  .o_evt(left_evt));
  clock_btn_edge u_right (.clk(i_clk), .rstn(i_rstn), .i_btn(i_right), .o_evt(right_evt));
  clock_btn_edge u_mode  (.clk(i_clk), .rstn(i_rstn), .i_btn(i_mode),  .o_evt(mode_evt));

  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic [PW-1:0] presc_q, presc_d;
  cursor_e       cursor_q, cursor_d;
  logic          fmt12_q, fmt12_d;
  logic          tick;

  assign tick = ~i_set && (presc_q == PRESC_LAST);

  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    presc_d  = presc_q;
    cursor_d = cursor_q;
    fmt12_d  = fmt12_q;

    if (mode_evt) fmt12_d = ~fmt12_q;

    if (i_set) begin
      presc_d = '0;
      // Edits target the cursor as it stood at the start of the cycle; up beats down.
      if (up_evt || down_evt) begin
        unique case (cursor_q)
          CUR_SEC: sec_d = up_evt ? inc_wrap(sec_q, SEC_MAX) : dec_wrap(sec_q, SEC_MAX);
          CUR_MIN: min_d = up_evt ? inc_wrap(min_q, MIN_MAX) : dec_wrap(min_q, MIN_MAX);
          CUR_HR:  hr_d  = up_evt ? 5'(inc_wrap({1'b0, hr_q}, {1'b0, HR_MAX}))
                                  : 5'(dec_wrap({1'b0, hr_q}, {1'b0, HR_MAX}));
          default: ;
        endcase
      end
      if (left_evt) begin
        unique case (cursor_q)
          CUR_SEC: cursor_d = CUR_MIN;
          CUR_MIN: cursor_d = CUR_HR;
          default: cursor_d = CUR_SEC;
        endcase
      end else if (right_evt) begin
        unique case (cursor_q)
          CUR_SEC: cursor_d = CUR_HR;
          CUR_HR:  cursor_d = CUR_MIN;
          default: cursor_d = CUR_SEC;
        endcase
      end
    end else if (tick) begin
      presc_d = '0;
      if (sec_q == SEC_MAX) begin
        sec_d = 6'd0;
        if (min_q == MIN_MAX) begin
          min_d = 6'd0;
          hr_d  = (hr_q == HR_MAX) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sec_q    <= 6'd0;
      min_q    <= 6'd0;
      hr_q     <= 5'd0;
      presc_q  <= '0;
      cursor_q <= CUR_SEC;
      fmt12_q  <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      presc_q  <= presc_d;
      cursor_q <= cursor_d;
      fmt12_q  <= fmt12_d;
    end
  end

  assign o_sec = sec_q;
  assign o_min = min_q;
  assign o_hr  = fmt12_q ? to_12h(hr_q) : hr_q;

endmodule

// File: tb/tb_clock_top.sv
// Randomised and directed bench for clock_top against a seconds-of-day reference model.
module tb_clock_top;

  localparam int N = 10;
  localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_MD = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] btn;
  logic       set;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hr;

  int n_checks = 0;
  int n_fail   = 0;

  clock_top #(.CLK_PER_SEC(N)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_up(btn[B_UP]), .i_down(btn[B_DN]), .i_left(btn[B_LT]), .i_right(btn[B_RT]),
    .i_mode(btn[B_MD]), .i_set(set),
    .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as seconds since midnight, cursor 0=sec 1=min 2=hr.
  int m_tod, m_run, m_cur;
  bit m_fmt12;
  bit [4:0] m_prev;

  task automatic model_step();
    bit [4:0] ev;
    int h, m, s;
    if (!rstn) begin
      m_tod = 0; m_run = 0; m_cur = 0; m_fmt12 = 0; m_prev = '0;
    end else begin
      ev = btn & ~m_prev;
      m_prev = btn;
      if (ev[B_MD]) m_fmt12 = !m_fmt12;
      if (set) begin
        m_run = 0;
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        if (ev[B_UP] || ev[B_DN]) begin
          int d;
          d = ev[B_UP] ? 1 : -1;
          case (m_cur)
            0: s = (s + d + 60) % 60;
            1: m = (m + d + 60) % 60;
            default: h = (h + d + 24) % 24;
          endcase
        end
        m_tod = h * 3600 + m * 60 + s;
        if (ev[B_LT])      m_cur = (m_cur + 1) % 3;
        else if (ev[B_RT]) m_cur = (m_cur + 2) % 3;
      end else begin
        m_run++;
        if (m_run == N) begin
          m_run = 0;
          m_tod = (m_tod + 1) % 86400;
        end
      end
    end
  endtask

  function automatic int exp_hr();
    int h;
    h = m_tod / 3600;
    if (!m_fmt12) return h;
    if (h == 0) return 12;
    return (h > 12) ? h - 12 : h;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      n_checks++;
      if (int'(o_sec) != m_tod % 60 || int'(o_min) != (m_tod / 60) % 60 || int'(o_hr) != exp_hr()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got %0d:%0d:%0d want %0d:%0d:%0d", $time,
                 o_hr, o_min, o_sec, exp_hr(), (m_tod / 60) % 60, m_tod % 60);
      end
    end
  end

  task automatic check(input string name, input int hr, input int mn, input int sc);
    n_checks++;
    if (int'(o_hr) != hr || int'(o_min) != mn || int'(o_sec) != sc) begin
      n_fail++;
      $display("FAIL %s got %0d:%0d:%0d want %0d:%0d:%0d", name, o_hr, o_min, o_sec, hr, mn, sc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    cycles(1);
    btn[b] = 1'b0;
    cycles(1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycles(2);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; btn = '0; set = 1'b0;
    cycles(2);
    rstn = 1'b1;
    check("reset", 0, 0, 0);

    cycles(30);
    check("run_30", 0, 0, 3);

    // Set-mode editing from a fresh reset.
    do_reset();
    set = 1'b1;
    btn[B_UP] = 1'b1; cycles(5); btn[B_UP] = 1'b0; cycles(1);
    check("up_held", 0, 0, 1);
    press(B_DN); press(B_DN);
    check("down_wrap_sec", 0, 0, 59);

    press(B_RT); press(B_UP);
    check("right_to_hr_up", 1, 0, 59);
    press(B_RT); press(B_DN);
    check("min_down_wrap", 1, 59, 59);
    press(B_LT); press(B_LT); press(B_UP);
    check("left_twice_sec", 1, 59, 0);

    btn[B_UP] = 1'b1; btn[B_DN] = 1'b1; cycles(1); btn = '0; cycles(1);
    check("up_down_up_wins", 1, 59, 1);
    btn[B_UP] = 1'b1; btn[B_LT] = 1'b1; cycles(1); btn = '0; cycles(1);
    check("up_left_old_field", 1, 59, 2);

    // Cursor now MIN: build 23:59:59.
    press(B_RT);
    press(B_DN); press(B_DN); press(B_DN);
    press(B_LT); press(B_LT);
    press(B_DN); press(B_DN);
    check("preload", 23, 59, 59);
    cycles(100);
    check("set_hold_frozen", 23, 59, 59);

    set = 1'b0;
    cycles(N - 1);
    check("before_first_tick", 23, 59, 59);
    cycles(1);
    check("midnight_wrap", 0, 0, 0);

    press(B_MD);
    check("fmt12_midnight", 12, 0, 0);
    set = 1'b1;
    repeat (13) press(B_UP);
    check("fmt12_13h", 1, 0, 0);
    press(B_MD);
    check("fmt24_13h", 13, 0, 0);

    set = 1'b0;
    cycles(25);
    rstn = 1'b0; btn = 5'b11111; cycles(1);
    rstn = 1'b1; btn = '0;
    check("midrun_reset", 0, 0, 0);
    set = 1'b1;
    press(B_UP);
    check("reset_cursor_fmt", 0, 0, 1);
    set = 1'b0;

    // Random phase: sparse button levels, occasional mode and reset changes.
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) btn[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) set = ~set;
      rstn = ($urandom_range(0, 499) != 0);
      if (!set && $urandom_range(0, 1) == 0) btn = '0;
      cycles(1);
    end
    rstn = 1'b1; btn = '0; set = 1'b0;
    cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
